// File: rtl/alu_sequencer_if.sv
// Command and ALU-side bundle between the decoder, the sequencer and the 8-bit ALU.
// Pure wiring, no latency.
// Command side uses valid/ready; ALU side is combinational feed-forward.
interface alu_sequencer_if #(
  parameter int COUNT_WIDTH = 3
);
  // Command channel from the instruction decoder
  logic                   cmd_vld;
  logic                   cmd_rdy;
  logic [3:0]             cmd_op;
  logic                   cmd_dest;
  logic [COUNT_WIDTH-1:0] cmd_count;
  logic [7:0]             cmd_dat;

  // ALU control and operands
  logic [2:0]             alu_control;
  logic                   reg_output_alu;
  logic [7:0]             alu_a;
  logic [7:0]             alu_b;

  // ALU results: one flag set per destination register
  logic [7:0]             alu_out;
  logic                   n_a;
  logic                   z_a;
  logic                   c_a;
  logic                   n_b;
  logic                   z_b;
  logic                   c_b;

  // Register file and status
  logic [7:0]             reg_a;
  logic [7:0]             reg_b;
  logic [2:0]             flags_a;
  logic [2:0]             flags_b;
  logic                   busy;
  logic                   done;
  logic                   error;

  // Sequencer side
  modport slave (
    input  cmd_vld, cmd_op, cmd_dest, cmd_count, cmd_dat,
    input  alu_out, n_a, z_a, c_a, n_b, z_b, c_b,
    output cmd_rdy, alu_control, reg_output_alu, alu_a, alu_b,
    output reg_a, reg_b, flags_a, flags_b, busy, done, error
  );

  // Decoder + ALU side
  modport master (
    output cmd_vld, cmd_op, cmd_dest, cmd_count, cmd_dat,
    output alu_out, n_a, z_a, c_a, n_b, z_b, c_b,
    input  cmd_rdy, alu_control, reg_output_alu, alu_a, alu_b,
    input  reg_a, reg_b, flags_a, flags_b, busy, done, error
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command at a time onto the ALU, owning the A/B registers and their N/Z/C flags.
// Latency: ALU op = N EXEC cycles (N = 1, or count+1 for shifts) + 1 DONE; load/illegal = 1 DONE.
// Backpressure: cmd_rdy only in IDLE; a held command waits there until the sequencer frees up.
module alu_sequencer #(
  parameter int         COUNT_WIDTH = 3,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  alu_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_op;
  logic                   r_dest;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_err;
  logic [7:0]             r_reg_a;
  logic [7:0]             r_reg_b;
  logic [2:0]             r_flags_a;
  logic [2:0]             r_flags_b;

  logic                   w_accept;
  logic                   w_is_alu;
  logic                   w_is_load;
  logic                   w_is_shift_cmd;
  logic                   w_exec;
  logic                   w_shift_on_b;
  logic [2:0]             w_alu_flags;

  assign w_accept       = bus.cmd_vld && (r_state == S_IDLE);
  assign w_is_alu       = (bus.cmd_op <= 4'd6);
  assign w_is_load      = (bus.cmd_op == 4'd8) || (bus.cmd_op == 4'd9);
  assign w_is_shift_cmd = (bus.cmd_op == 4'd5) || (bus.cmd_op == 4'd6);
  assign w_exec         = (r_state == S_EXEC);

  // A shift targeting B must feed B into the ALU's A port, since the ALU only shifts operand A.
  assign w_shift_on_b   = w_exec && r_dest && ((r_op == 3'd5) || (r_op == 3'd6));

  // The ALU keeps a flag set per destination; take the one matching where the result lands.
  assign w_alu_flags    = r_dest ? {bus.n_b, bus.z_b, bus.c_b} : {bus.n_a, bus.z_a, bus.c_a};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: ALU ops run through EXEC, loads and illegal ops go straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_is_alu ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch command fields at accept; count down the remaining shift iterations in EXEC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op   <= 3'd0;
      r_dest <= 1'b0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.cmd_op[2:0];
      r_dest <= bus.cmd_dest;
      r_cnt  <= w_is_shift_cmd ? bus.cmd_count : '0;
      r_err  <= !(w_is_alu || w_is_load);
    end else if (w_exec && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end

  // Register file: immediate loads at accept, ALU writeback on every EXEC edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_a   <= RESET_VALUE;
      r_reg_b   <= RESET_VALUE;
      r_flags_a <= 3'b000;
      r_flags_b <= 3'b000;
    end else if (w_accept && w_is_load) begin
      if (bus.cmd_op[0]) begin
        r_reg_b   <= bus.cmd_dat;
        r_flags_b <= {bus.cmd_dat[7], (bus.cmd_dat == 8'h00), 1'b0};
      end else begin
        r_reg_a   <= bus.cmd_dat;
        r_flags_a <= {bus.cmd_dat[7], (bus.cmd_dat == 8'h00), 1'b0};
      end
    end else if (w_exec) begin
      if (r_dest) begin
        r_reg_b   <= bus.alu_out;
        r_flags_b <= w_alu_flags;
      end else begin
        r_reg_a   <= bus.alu_out;
        r_flags_a <= w_alu_flags;
      end
    end
  end

  assign bus.cmd_rdy        = (r_state == S_IDLE);
  assign bus.busy           = (r_state == S_EXEC) || (r_state == S_DONE);
  assign bus.done           = (r_state == S_DONE) && !r_err;
  assign bus.error          = (r_state == S_DONE) && r_err;
  assign bus.alu_control    = w_exec ? r_op : 3'd0;
  assign bus.reg_output_alu = w_exec ? r_dest : 1'b0;
  assign bus.alu_a          = w_shift_on_b ? r_reg_b : r_reg_a;
  assign bus.alu_b          = r_reg_b;
  assign bus.reg_a          = r_reg_a;
  assign bus.reg_b          = r_reg_b;
  assign bus.flags_a        = r_flags_a;
  assign bus.flags_b        = r_flags_b;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a single-step ALU model and a transaction-level scoreboard.
// The scoreboard computes each command's final result in one go and is compared every cycle.
// Stimulus holds cmd_vld high across busy periods to exercise backpressure.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_sequencer_if ifc ();

  alu_sequencer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-cycle ALU: one operation per cycle, shifts move one bit.
  logic [7:0] alu_res;
  logic       alu_c;
  logic [2:0] alu_fl;

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (ifc.alu_control)
      3'd0: {alu_c, alu_res} = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
      3'd1: begin alu_res = ifc.alu_a - ifc.alu_b; alu_c = (ifc.alu_a < ifc.alu_b); end
      3'd2: begin alu_res = ifc.alu_b - ifc.alu_a; alu_c = (ifc.alu_b < ifc.alu_a); end
      3'd3: alu_res = ifc.alu_a & ifc.alu_b;
      3'd4: alu_res = ifc.alu_a | ifc.alu_b;
      3'd5: {alu_c, alu_res} = {ifc.alu_a, 1'b0};
      3'd6: begin alu_res = {1'b0, ifc.alu_a[7:1]}; alu_c = ifc.alu_a[0]; end
      default: ;
    endcase
    alu_fl = {alu_res[7], (alu_res == 8'h00), alu_c};
  end

  // Only the selected flag set carries real flags; the other carries inverted garbage.
  assign ifc.alu_out = alu_res;
  assign {ifc.n_a, ifc.z_a, ifc.c_a} = ifc.reg_output_alu ? ~alu_fl : alu_fl;
  assign {ifc.n_b, ifc.z_b, ifc.c_b} = ifc.reg_output_alu ? alu_fl : ~alu_fl;

  // Scoreboard state. Between a negedge and the next posedge it describes the state after that posedge.
  logic [7:0] m_a  = 8'h00;
  logic [7:0] m_b  = 8'h00;
  logic [2:0] m_fa = 3'b000;
  logic [2:0] m_fb = 3'b000;
  logic [3:0] m_op = 4'h0;
  logic       m_dest = 1'b0;
  logic       m_ill  = 1'b0;
  logic       m_pend = 1'b0;
  logic [7:0] m_r    = 8'h00;
  logic [2:0] m_f    = 3'b000;
  int         m_timer = 0;   // cycles until IDLE; 1 means the DONE cycle
  int         m_n     = 0;   // EXEC cycles of the current ALU op
  bit         m_valid = 1'b0;

  // Compare against the model, then advance the model across the upcoming posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        logic       in_exec;
        logic [7:0] src;
        in_exec = (m_timer > 1);
        src     = ((m_op >= 4'd5) && m_dest) ? m_b : m_a;
        chk("cmd_rdy", ifc.cmd_rdy, (m_timer == 0));
        chk("busy",    ifc.busy,    (m_timer != 0));
        chk("done",    ifc.done,    (m_timer == 1) && !m_ill);
        chk("error",   ifc.error,   (m_timer == 1) && m_ill);
        chk("alu_control", ifc.alu_control, in_exec ? m_op[2:0] : 3'd0);
        chk("reg_output_alu", ifc.reg_output_alu, in_exec ? m_dest : 1'b0);
        if (!in_exec) begin
          chk("reg_a",   ifc.reg_a,   m_a);
          chk("reg_b",   ifc.reg_b,   m_b);
          chk("flags_a", ifc.flags_a, m_fa);
          chk("flags_b", ifc.flags_b, m_fb);
          chk("alu_a_idle", ifc.alu_a, m_a);
          chk("alu_b_idle", ifc.alu_b, m_b);
        end else if (m_timer == m_n + 1) begin
          chk("alu_a_exec", ifc.alu_a, src);
          chk("alu_b_exec", ifc.alu_b, m_b);
        end
      end

      if (rst) begin
        m_a = 8'h00; m_b = 8'h00; m_fa = 3'b000; m_fb = 3'b000;
        m_timer = 0; m_pend = 1'b0; m_ill = 1'b0; m_op = 4'h0; m_dest = 1'b0;
        m_valid = 1'b1;
      end else if (m_timer == 0) begin
        if (ifc.cmd_vld) begin
          logic [7:0]  src;
          logic [15:0] w;
          int          k;
          m_op = ifc.cmd_op; m_dest = ifc.cmd_dest; m_ill = 1'b0; m_pend = 1'b0;
          if (m_op <= 4'd6) begin
            k       = (m_op >= 4'd5) ? int'(ifc.cmd_count) + 1 : 1;
            m_n     = k;
            m_timer = k + 1;
            m_pend  = 1'b1;
            src     = ((m_op >= 4'd5) && m_dest) ? m_b : m_a;
            w       = 16'h0000;
            case (m_op)
              4'd0: begin w = {8'h00, m_a} + {8'h00, m_b}; m_r = w[7:0]; alu_c_model(w[8]); end
              4'd1: begin m_r = m_a - m_b; alu_c_model(m_a < m_b); end
              4'd2: begin m_r = m_b - m_a; alu_c_model(m_b < m_a); end
              4'd3: begin m_r = m_a & m_b; alu_c_model(1'b0); end
              4'd4: begin m_r = m_a | m_b; alu_c_model(1'b0); end
              4'd5: begin w = {8'h00, src} << k; m_r = w[7:0]; alu_c_model(w[8]); end
              default: begin m_r = src >> k; alu_c_model(src[k-1]); end
            endcase
          end else if ((m_op == 4'd8) || (m_op == 4'd9)) begin
            m_timer = 1;
            if (m_op == 4'd9) begin
              m_b = ifc.cmd_dat; m_fb = {ifc.cmd_dat[7], (ifc.cmd_dat == 8'h00), 1'b0};
            end else begin
              m_a = ifc.cmd_dat; m_fa = {ifc.cmd_dat[7], (ifc.cmd_dat == 8'h00), 1'b0};
            end
          end else begin
            m_ill   = 1'b1;
            m_timer = 1;
          end
        end
      end else begin
        m_timer = m_timer - 1;
        if ((m_timer == 1) && m_pend) begin
          if (m_dest) begin m_b = m_r; m_fb = m_f; end
          else        begin m_a = m_r; m_fa = m_f; end
          m_pend = 1'b0;
        end
      end
    end
  end

  // Final flags of a whole command from its result and carry-out.
  task automatic alu_c_model(input logic c);
    m_f = {m_r[7], (m_r == 8'h00), c};
  endtask

  // Present a command and hold it until the model says it has been accepted.
  task automatic send(input logic [3:0] op, input logic dest, input logic [2:0] cnt, input logic [7:0] dat);
    bit acc;
    acc = 1'b0;
    ifc.cmd_op = op; ifc.cmd_dest = dest; ifc.cmd_count = cnt; ifc.cmd_dat = dat;
    ifc.cmd_vld = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      if (m_timer == 0) acc = 1'b1;
      @(posedge clk); #1;
    end
    if (!acc) begin
      miscompares++;
      $display("FAIL send_accept: op %0h not accepted within 64 cycles", op);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    ifc.cmd_vld = 1'b0; ifc.cmd_op = 4'h0; ifc.cmd_dest = 1'b0;
    ifc.cmd_count = 3'd0; ifc.cmd_dat = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_rdy",   ifc.cmd_rdy, 1);
    chk("rst_busy",  ifc.busy, 0);
    chk("rst_reg_a", ifc.reg_a, 8'h00);
    chk("rst_ctl",   ifc.alu_control, 3'd0);

    // Load/add: 7F + 01 into A
    send(4'd8, 1'b0, 3'd0, 8'h7F);
    send(4'd9, 1'b0, 3'd0, 8'h01);
    send(4'd0, 1'b0, 3'd0, 8'h00);
    ifc.cmd_vld = 1'b0;
    chk("add_exec_done", ifc.done, 0);
    step();
    chk("add_done",    ifc.done, 1);
    chk("add_reg_a",   ifc.reg_a, 8'h80);
    chk("add_flags_a", ifc.flags_a, 3'b100);
    chk("add_flags_b", ifc.flags_b, 3'b000);
    step();

    // Borrow: A - B into B
    send(4'd8, 1'b0, 3'd0, 8'h05);
    send(4'd9, 1'b0, 3'd0, 8'h05);
    send(4'd1, 1'b1, 3'd0, 8'h00);
    ifc.cmd_vld = 1'b0;
    chk("sub_sel", ifc.reg_output_alu, 1);
    chk("sub_ctl", ifc.alu_control, 3'd1);
    step();
    chk("sub_reg_b",   ifc.reg_b, 8'h00);
    chk("sub_flags_b", ifc.flags_b, 3'b010);
    step();

    // Repeated shift: 81 << 3 = 08, then 03 >> 1 on B
    send(4'd8, 1'b0, 3'd0, 8'h81);
    send(4'd5, 1'b0, 3'd2, 8'h00);
    ifc.cmd_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("shl_exec_busy", ifc.busy, 1);
      chk("shl_exec_ctl",  ifc.alu_control, 3'd5);
      step();
    end
    chk("shl_done",    ifc.done, 1);
    chk("shl_reg_a",   ifc.reg_a, 8'h08);
    chk("shl_flags_a", ifc.flags_a, 3'b000);
    step();
    send(4'd9, 1'b0, 3'd0, 8'h03);
    send(4'd6, 1'b1, 3'd0, 8'h00);
    ifc.cmd_vld = 1'b0;
    step();
    chk("shr_reg_b",   ifc.reg_b, 8'h01);
    chk("shr_flags_b", ifc.flags_b, 3'b001);
    step();

    // Shift by 8 empties the register; carry is the original bit 0
    send(4'd8, 1'b0, 3'd0, 8'hFF);
    send(4'd5, 1'b0, 3'd7, 8'h00);
    ifc.cmd_vld = 1'b0;
    repeat (8) step();
    chk("shl8_reg_a",   ifc.reg_a, 8'h00);
    chk("shl8_flags_a", ifc.flags_a, 3'b011);
    step();

    // Illegal op leaves state untouched
    send(4'd8, 1'b0, 3'd0, 8'h5A);
    send(4'hC, 1'b1, 3'd0, 8'hAA);
    ifc.cmd_vld = 1'b0;
    chk("ill_error", ifc.error, 1);
    chk("ill_done",  ifc.done, 0);
    chk("ill_reg_a", ifc.reg_a, 8'h5A);
    step();
    chk("ill_error_clr", ifc.error, 0);

    // Back-to-back with cmd_vld held high throughout
    send(4'd8, 1'b0, 3'd0, 8'h3C);   // A = 3C
    send(4'd0, 1'b1, 3'd0, 8'h00);   // B = 3C + 01 = 3D
    send(4'd6, 1'b0, 3'd1, 8'h00);   // A = 3C >> 2 = 0F
    send(4'd4, 1'b0, 3'd0, 8'h00);   // A = 0F | 3D = 3F
    send(4'd2, 1'b0, 3'd0, 8'h00);   // A = 3D - 3F = FE
    send(4'd3, 1'b1, 3'd0, 8'h00);   // B = FE & 3D = 3C
    send(4'd9, 1'b0, 3'd0, 8'h00);   // B = 00
    send(4'd7, 1'b0, 3'd0, 8'h00);   // illegal
    send(4'd1, 1'b0, 3'd0, 8'h00);   // A = FE - 00 = FE
    ifc.cmd_vld = 1'b0;
    repeat (4) step();
    chk("b2b_reg_a",   ifc.reg_a, 8'hFE);
    chk("b2b_reg_b",   ifc.reg_b, 8'h00);
    chk("b2b_flags_a", ifc.flags_a, 3'b100);
    chk("b2b_flags_b", ifc.flags_b, 3'b010);

    // Reset in the second EXEC cycle of a count-7 shift
    send(4'd8, 1'b0, 3'd0, 8'hC3);
    send(4'd9, 1'b0, 3'd0, 8'h96);
    send(4'd5, 1'b0, 3'd7, 8'h00);
    ifc.cmd_vld = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_reg_a",   ifc.reg_a, 8'h00);
    chk("mid_rst_reg_b",   ifc.reg_b, 8'h00);
    chk("mid_rst_flags_a", ifc.flags_a, 3'b000);
    chk("mid_rst_rdy",     ifc.cmd_rdy, 1);
    chk("mid_rst_done",    ifc.done, 0);
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller that owns the A/B operand registers and per-register N/Z/C flag registers feeding the 8-bit ALU.
- Accepts one command at a time over a valid/ready handshake and drives the ALU control lines (op code and output-register select).
- Writes the ALU result and flags back into the destination register, and repeats shift ops for multi-bit shifts.
- Sits between the instruction decoder and the ALU.

Parameters:
- COUNT_WIDTH, 3: width of the repeat field. A shift executes iCmdCount+1 times, so 1..8 iterations.
- RESET_VALUE, 8'h00: reset value of both operand registers.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iCmdValid  in  1  command present.
- oCmdReady  out  1  sequencer can accept a command.
- iCmdOp  in  4  0-6 = ALU op in ALU encoding (ADD, A-B, B-A, AND, OR, SHL, SHR); 8 = load A; 9 = load B; others illegal.
- iCmdDest  in  1  destination of an ALU op: 0 = A, 1 = B.
- iCmdCount  in  COUNT_WIDTH  repeat count minus one (shifts only).
- iCmdData  in  8  immediate for loads.
- oALUControl  out  3  drives the ALU op select.
- oRegOutputALU  out  1  drives the ALU flag-set select (= destination).
- oALUA, oALUB  out  8 each  ALU operand inputs.
- iALUOut  in  8  ALU result.
- iN_A, iZ_A, iC_A, iN_B, iZ_B, iC_B  in  1 each  ALU flags.
- oRegA, oRegB  out  8 each  register contents.
- oFlagsA, oFlagsB  out  3 each  {N,Z,C} per register.
- oBusy  out  1  high in EXEC and DONE.
- oDone  out  1  one-cycle completion pulse for a legal command.
- oError  out  1  one-cycle pulse for an illegal op.

Behaviour:
- **Reset:**
  - State IDLE.
  - oRegA = oRegB = RESET_VALUE; oFlagsA = oFlagsB = 3'b000.
  - oALUControl = 0, oRegOutputALU = 0.
  - oDone = oError = oBusy = 0; oCmdReady = 1.
  - Reset in any state aborts the command in flight: no writeback, no oDone.
- **Handshake:**
  - oCmdReady = 1 only in IDLE.
  - A command is accepted on an edge where iCmdValid & oCmdReady; all fields are latched at that edge.
  - iCmdValid while not ready is ignored. The requester holds the command until accepted.
- **States:** IDLE, EXEC, DONE.
  - IDLE + accepted ALU op (0-6) -> EXEC. The internal counter loads iCmdCount for ops 5/6 and 0 for ops 0-4.
  - IDLE + accepted load (8/9) -> DONE. At the accept edge the destination register gets iCmdData and its flags get N = data[7], Z = (data == 0), C = 0.
  - IDLE + accepted illegal op (7, 10-15) -> DONE with the error flag set. No register or flag change.
  - EXEC, every cycle:
    - oALUControl = latched op; oRegOutputALU = latched dest.
    - At the edge, the destination register gets iALUOut and the destination flags get {N,Z,C} from the ALU flag set selected by dest. The other register's flags are unchanged.
    - Counter == 0 -> DONE; otherwise decrement and stay in EXEC.
  - DONE: oDone = 1 (legal) or oError = 1 (illegal) for exactly one cycle, then -> IDLE.
- **Operand routing:**
  - Ops 0-4: oALUA = oRegA, oALUB = oRegB.
  - Ops 5/6 with dest = B: oALUA = oRegB, so a shift always operates on its destination register.
  - Outside EXEC: oALUA = oRegA, oALUB = oRegB, oALUControl = 0, oRegOutputALU = 0. Flags are not sampled outside EXEC.
- **Latency:**
  - ALU op: N EXEC cycles (N = 1 for ops 0-4; N = count+1 for shifts), then 1 DONE cycle. Next accept at the earliest N+2 cycles after the previous accept.
  - Load or illegal op: 1 DONE cycle; next accept 2 cycles after.
- **Arithmetic:**
  - 8-bit wrap-around exactly as the ALU produces it. The sequencer does no arithmetic of its own.
  - Multi-iteration shift: the final flags come from the last iteration. C is the last bit shifted out.
  - Shifting by 8 yields 0 with Z = 1.
- **Outputs:** oRegA/oRegB and the flag outputs are registered. oCmdReady, oBusy, oDone and oError decode from state.

Test Plan:
- **Load/add:** Load A 8'h7F, load B 8'h01, ADD dest A.
  - Expect A = 8'h80, flagsA = {1,0,0}, flagsB unchanged at {0,0,0}.
  - oDone pulses 2 cycles after the ADD is accepted.
- **Borrow:** A = 8'h05, B = 8'h05, op 1 dest B.
  - Expect B = 8'h00, flagsB Z = 1. Confirm oRegOutputALU = 1 during EXEC.
- **Repeated shift:**
  - A = 8'h81, op 5 count 2 dest A: exactly 3 EXEC cycles, then A = 8'h08 and C = 0.
  - Then load B 8'h03, op 6 count 0 dest B: B = 8'h01, C = 1.
- **Handshake:**
  - Hold iCmdValid high continuously with back-to-back commands. Each command is accepted only when oCmdReady = 1.
  - A command presented during EXEC is not lost once held; no command is double-accepted.
- **Illegal op:** op 4'hC.
  - Expect oError pulse after 1 cycle, no oDone, registers and flags unchanged.
- **Reset mid-op:** Assert Reset during the 2nd EXEC cycle of a count-7 shift.
  - Next cycle: A = B = 8'h00, flags 0, IDLE, oCmdReady = 1, no oDone.
